// File: rtl/exec_controller_if.sv
// Signal bundle between the uPC bring-up harness and exec_controller: buttons, PC/breakpoint in,
// run-control status out.
interface exec_controller_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             btn_run;
  logic             btn_step;
  logic             btn_halt;
  logic [PC_W-1:0]  pc_count;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_valid;
  logic             cpu_en;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output btn_run, btn_step, btn_halt, pc_count, bp_addr, bp_valid,
    input  cpu_en, halted, state, instr_count
  );

  modport slave (
    input  btn_run, btn_step, btn_halt, pc_count, bp_addr, bp_valid,
    output cpu_en, halted, state, instr_count
  );
endinterface

// File: rtl/exec_controller.sv
// Run/halt/single-step sequencer producing the uPC core clock enable from debounced buttons.
// Breakpoint support is compiled in only when EXEC_CTRL_BREAKPOINT_EN is defined.
module exec_controller #(
  parameter int PC_W            = 8,
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int CNT_W           = 16
) (
  input logic               CLK,
  input logic               reset,
  exec_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_BRK  = 2'd3
  } state_t;

  localparam int            DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

  // Button index: 0 = run, 1 = step, 2 = halt.
  logic [2:0]      raw;
  logic [2:0]      sync1, sync2;
  logic [2:0]      deb, deb_d;
  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      press;
  logic            halt_p, step_p, run_p;

  state_t          state_q, state_d;
  logic            cpu_en;
  logic            active;
  logic            hit;
  logic [CNT_W-1:0] instr_q;

  assign raw = {bus.btn_halt, bus.btn_step, bus.btn_run};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the counter array is small control state, so it is reset like any other register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (!sync2[i]) begin
          db_cnt[i] <= '0;
          deb[i]    <= 1'b0;
        end else begin
          if (db_cnt[i] != DB_MAX) db_cnt[i] <= db_cnt[i] + 1'b1;
          if (db_cnt[i] == DB_MAX) deb[i] <= 1'b1;
        end
      end
    end
  end

  assign press  = deb & ~deb_d;
  assign halt_p = press[2];
  assign step_p = press[1] & ~press[2];
  assign run_p  = press[0] & ~press[1] & ~press[2];

  assign active = (state_q == S_RUN) || (state_q == S_STEP);

`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic skip;

  assign hit = active & bus.bp_valid & (bus.pc_count == bus.bp_addr) & ~skip;

  // skip lets the core execute the breakpoint instruction once after leaving BRK.
  always_ff @(posedge CLK) begin
    if (reset)                                   skip <= 1'b0;
    else if (state_q == S_BRK && state_d != S_BRK) skip <= 1'b1;
    else if (cpu_en)                             skip <= 1'b0;
  end
`else
  logic unused_bp;

  assign hit       = 1'b0;
  assign unused_bp = ^{bus.bp_valid, bus.bp_addr, bus.pc_count};
`endif

  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_HALT;
    else       state_q <= state_d;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cpu_en  = 1'b0;
    case (state_q)
      S_HALT: begin
        if (halt_p)      state_d = S_HALT;
        else if (step_p) state_d = S_STEP;
        else if (run_p)  state_d = S_RUN;
      end
      S_RUN: begin
        cpu_en = ~hit;
        if (halt_p)   state_d = S_HALT;
        else if (hit) state_d = S_BRK;
      end
      S_STEP: begin
        cpu_en  = ~hit;
        state_d = hit ? S_BRK : S_HALT;
      end
      S_BRK: begin
        if (halt_p)      state_d = S_HALT;
        else if (step_p) state_d = S_STEP;
        else if (run_p)  state_d = S_RUN;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset)                         instr_q <= '0;
    else if (cpu_en && instr_q != '1) instr_q <= instr_q + 1'b1;
  end

  assign bus.cpu_en      = cpu_en;
  assign bus.halted      = (state_q == S_HALT) || (state_q == S_BRK);
  assign bus.state       = state_q;
  assign bus.instr_count = instr_q;

endmodule
